pe_array_feeder: RTL

//  Transmit-side driver for PE_array. Accepts grouped weight/activation words on a valid/ready

---
 rtl/pe_array_feeder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_array_feeder.sv
// pe_array_feeder: ping-pong group buffer feeding the PE_array data_in bus,
// then collecting the serial psums once the array latency has elapsed.
module pe_array_feeder #(
  parameter int O_CH       = 6,
  parameter int ROW_LENGTH = 11,
  parameter int K          = 10,
  parameter int WIDTH      = 14,
  parameter int DRAIN_LAT  = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic             in_valid,
  input  logic [26:0]      in_data,
  output logic             in_ready,
  output logic [26:0]      data_out,
  input  logic [WIDTH-1:0] psum_in,
  output logic             psum_valid,
  output logic [WIDTH-1:0] psum_data,
  output logic [2:0]       psum_idx,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int TOTAL = ROW_LENGTH * K;
  localparam int GW    = $clog2(TOTAL + 1);
  localparam int IW    = $clog2(O_CH + 1);

  localparam logic [GW-1:0] TOT_G  = GW'(TOTAL);
  localparam logic [GW-1:0] LAST_G = GW'(TOTAL - 1);
  localparam logic [GW-1:0] ONE_G  = GW'(1);
  localparam logic [IW-1:0] LAST_I = IW'(O_CH);
  localparam logic [IW-1:0] ONE_I  = IW'(1);
  localparam logic [2:0]    LAST_P = 3'(O_CH - 1);
  localparam logic [1:0]    LAST_D = 2'(DRAIN_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, STREAM, DRAIN, COLLECT, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [26:0]       buf_q [2][O_CH+1];
  logic [26:0]       buf_d [2][O_CH+1];
  logic [1:0]        full_q, full_d;
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [IW-1:0]     ridx_q, ridx_d;
  logic [GW-1:0]     gin_q, gin_d;
  logic [GW-1:0]     gout_q, gout_d;
  logic [1:0]        drain_q, drain_d;
  logic [2:0]        pcnt_q, pcnt_d;
  logic [26:0]       dout_q, dout_d;
  logic              pv_q, pv_d;
  logic [WIDTH-1:0]  pd_q, pd_d;
  logic [2:0]        pidx_q, pidx_d;
  logic              ur_q, ur_d;
  logic              accept;

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign in_ready   = busy && !full_q[wsel_q] && (gin_q < TOT_G);
  assign accept     = in_valid && in_ready;
  assign data_out   = dout_q;
  assign psum_valid = pv_q;
  assign psum_data  = pd_q;
  assign psum_idx   = pidx_q;
  assign underrun   = ur_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    full_d  = full_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    gin_d   = gin_q;
    gout_d  = gout_q;
    drain_d = drain_q;
    pcnt_d  = pcnt_q;
    dout_d  = '0;
    pv_d    = 1'b0;
    pd_d    = pd_q;
    pidx_d  = '0;
    ur_d    = ur_q;

    if (accept) begin
      buf_d[wsel_q][widx_q] = in_data;
      if (widx_q == LAST_I) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = !wsel_q;
        widx_d         = '0;
        gin_d          = gin_q + ONE_G;
      end else begin
        widx_d = widx_q + ONE_I;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          ur_d    = 1'b0;
          full_d  = '0;
          wsel_d  = 1'b0;
          rsel_d  = 1'b0;
          widx_d  = '0;
          ridx_d  = '0;
          gin_d   = '0;
          gout_d  = '0;
          drain_d = '0;
          pcnt_d  = '0;
        end
      end
      FILL: begin
        if (full_q[rsel_q]) state_d = STREAM;
      end
      STREAM: begin
        if (full_q[rsel_q]) begin
          dout_d = buf_q[rsel_q][ridx_q];
          if (ridx_q == LAST_I) begin
            // the writer only targets a non-full bank, so this
            // clear never collides with the set above
            full_d[rsel_q] = 1'b0;
            rsel_d         = !rsel_q;
            ridx_d         = '0;
            gout_d         = gout_q + ONE_G;
            if (gout_q == LAST_G) begin
              state_d = DRAIN;
              drain_d = '0;
            end
          end else begin
            ridx_d = ridx_q + ONE_I;
          end
        end else begin
          ur_d = 1'b1;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == LAST_D) begin
          state_d = COLLECT;
          pv_d    = 1'b1;
          pd_d    = psum_in;
          pcnt_d  = 3'd1;
        end
      end
      COLLECT: begin
        pv_d   = 1'b1;
        pd_d   = psum_in;
        pidx_d = pcnt_q;
        pcnt_d = pcnt_q + 3'd1;
        if (pcnt_q == LAST_P) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i <= O_CH; i++) begin
          buf_q[b][i] <= '0;
        end
      end
      full_q  <= '0;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      widx_q  <= '0;
      ridx_q  <= '0;
      gin_q   <= '0;
      gout_q  <= '0;
      drain_q <= '0;
      pcnt_q  <= '0;
      dout_q  <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      pidx_q  <= '0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      gin_q   <= gin_d;
      gout_q  <= gout_d;
      drain_q <= drain_d;
      pcnt_q  <= pcnt_d;
      dout_q  <= dout_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      pidx_q  <= pidx_d;
      ur_q    <= ur_d;
    end
  end

endmodule
